// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer that steps a select code through a programmable range with a per-code dwell.
// Feeds the 4-to-16 one-hot decoder; active qualifies sel for downstream gating.
module decoder_scan_sequencer #(
   parameter int unsigned SEL_W   = 4,
   parameter int unsigned DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               mode_cont,
   input  logic [SEL_W-1:0]   first,
   input  logic [SEL_W-1:0]   last,
   input  logic [DWELL_W-1:0] dwell,
   output logic [SEL_W-1:0]   sel,
   output logic               active,
   output logic               step,
   output logic               done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_d;
   logic               active_d, step_d, done_d;
   logic [SEL_W-1:0]   first_q, first_d;
   logic [SEL_W-1:0]   last_q, last_d;
   logic               cont_q, cont_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;

   logic [DWELL_W-1:0] dwell_eff_c;
   logic               dwell_end_c;

   // A dwell of zero behaves as one cycle per code.
   assign dwell_eff_c = (dwell == '0) ? DWELL_W'(1) : dwell;
   // dwell_q is never zero, so the subtraction cannot underflow.
   assign dwell_end_c = (cnt_q == (dwell_q - DWELL_W'(1)));

   // State, output and latched-configuration registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel     <= '0;
         active  <= 1'b0;
         step    <= 1'b0;
         done    <= 1'b0;
         first_q <= '0;
         last_q  <= '0;
         cont_q  <= 1'b0;
         dwell_q <= DWELL_W'(1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel     <= sel_d;
         active  <= active_d;
         step    <= step_d;
         done    <= done_d;
         first_q <= first_d;
         last_q  <= last_d;
         cont_q  <= cont_d;
         dwell_q <= dwell_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel;
      active_d = active;
      step_d   = 1'b0;
      done_d   = 1'b0;
      first_d  = first_q;
      last_d   = last_q;
      cont_d   = cont_q;
      dwell_d  = dwell_q;
      cnt_d    = cnt_q;

      case (state_q)
         IDLE: begin
            active_d = 1'b0;
            // stop has priority over start so a simultaneous request is dropped
            if (start && !stop) begin
               first_d  = first;
               last_d   = last;
               cont_d   = mode_cont;
               dwell_d  = dwell_eff_c;
               sel_d    = first;
               active_d = 1'b1;
               step_d   = 1'b1;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               active_d = 1'b0;
               state_d  = IDLE;
            end else if (!dwell_end_c) begin
               cnt_d = cnt_q + DWELL_W'(1);
            end else begin
               cnt_d = '0;
               if (sel == last_q) begin
                  if (cont_q) begin
                     sel_d  = first_q;
                     step_d = 1'b1;
                  end else begin
                     active_d = 1'b0;
                     done_d   = 1'b1;
                     state_d  = IDLE;
                  end
               end else begin
                  // natural modulo-2^SEL_W wrap handles first > last ranges
                  sel_d  = sel + SEL_W'(1);
                  step_d = 1'b1;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            active_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Self-checking bench for decoder_scan_sequencer: vector table plus hand-written multi-cycle sequences.
module tb_decoder_scan_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start, stop, mode_cont;
   logic [3:0]  first, last;
   logic [15:0] dwell;
   logic [3:0]  sel;
   logic        active, step, done;

   int n_chk  = 0;
   int n_fail = 0;

   decoder_scan_sequencer #(.SEL_W(4), .DWELL_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .mode_cont (mode_cont),
      .first     (first),
      .last      (last),
      .dwell     (dwell),
      .sel       (sel),
      .active    (active),
      .step      (step),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic        stop;
      logic        cont;
      logic [3:0]  first;
      logic [3:0]  last;
      logic [15:0] dwell;
      logic [3:0]  e_sel;
      logic        e_act;
      logic        e_step;
      logic        e_done;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input int idx, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0d expected %0d at %0t", nm, idx, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string nm, input int idx, input int e_sel, input int e_act,
                          input int e_step, input int e_done);
      chk({nm, ".sel"},    idx, int'(sel),    e_sel);
      chk({nm, ".active"}, idx, int'(active), e_act);
      chk({nm, ".step"},   idx, int'(step),   e_step);
      chk({nm, ".done"},   idx, int'(done),   e_done);
   endtask

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic sp, input logic c,
                        input logic [3:0] f, input logic [3:0] l, input logic [15:0] d);
      start = st; stop = sp; mode_cont = c; first = f; last = l; dwell = d;
   endtask

   initial begin
      int steps, act_cycles;
      rst_n = 1'b0;
      drive(0, 0, 0, 4'd0, 4'd0, 16'd0);

      // {start, stop, cont, first, last, dwell, exp sel, active, step, done} after the next edge
      vecs[0]  = '{0, 0, 0, 4'd0,  4'd0, 16'd0, 4'd0,  0, 0, 0};
      vecs[1]  = '{1, 1, 0, 4'd3,  4'd6, 16'd2, 4'd0,  0, 0, 0};
      vecs[2]  = '{1, 0, 0, 4'd9,  4'd9, 16'd0, 4'd9,  1, 1, 0};
      vecs[3]  = '{0, 0, 0, 4'd0,  4'd0, 16'd0, 4'd9,  0, 0, 1};
      vecs[4]  = '{1, 0, 1, 4'd14, 4'd1, 16'd1, 4'd14, 1, 1, 0};
      vecs[5]  = '{0, 0, 0, 4'd2,  4'd3, 16'd7, 4'd15, 1, 1, 0};
      vecs[6]  = '{0, 0, 0, 4'd0,  4'd0, 16'd0, 4'd0,  1, 1, 0};
      vecs[7]  = '{0, 0, 0, 4'd0,  4'd0, 16'd0, 4'd1,  1, 1, 0};
      vecs[8]  = '{1, 0, 0, 4'd5,  4'd5, 16'd3, 4'd14, 1, 1, 0};
      vecs[9]  = '{0, 0, 0, 4'd0,  4'd0, 16'd0, 4'd15, 1, 1, 0};
      vecs[10] = '{0, 1, 0, 4'd0,  4'd0, 16'd0, 4'd15, 0, 0, 0};
      vecs[11] = '{0, 0, 0, 4'd0,  4'd0, 16'd0, 4'd15, 0, 0, 0};

      #12;
      chk_out("reset", 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      cyc();
      chk_out("post_reset", 0, 0, 0, 0, 0);

      // Table: arbitration, dwell 0 with equal bounds, continuous wrap, start ignored in RUN, stop.
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].start, vecs[i].stop, vecs[i].cont, vecs[i].first, vecs[i].last, vecs[i].dwell);
         cyc();
         chk_out("vec", i, int'(vecs[i].e_sel), int'(vecs[i].e_act), int'(vecs[i].e_step),
                 int'(vecs[i].e_done));
      end
      drive(0, 0, 0, 4'd0, 4'd0, 16'd0);

      // Single-shot 2..5, dwell 3.
      drive(1, 0, 0, 4'd2, 4'd5, 16'd3);
      steps = 0;
      act_cycles = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (i == 0) drive(0, 0, 1, 4'd0, 4'd0, 16'd1);
         chk_out("single", i, 2 + i / 3, 1, (i % 3 == 0) ? 1 : 0, 0);
         if (step) steps++;
         if (active) act_cycles++;
      end
      cyc();
      chk_out("single_end", 0, 5, 0, 0, 1);
      chk("single_steps", 0, steps, 4);
      chk("single_active", 0, act_cycles, 12);
      cyc();
      chk_out("single_after", 0, 5, 0, 0, 0);

      // Stop during the second cycle of code 3.
      drive(1, 0, 0, 4'd3, 4'd6, 16'd4);
      cyc();
      drive(0, 0, 0, 4'd0, 4'd0, 16'd0);
      chk_out("stop_c1", 0, 3, 1, 1, 0);
      cyc();
      chk_out("stop_c2", 0, 3, 1, 0, 0);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk_out("stop_fall", 0, 3, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk_out("stop_idle", i, 3, 0, 0, 0);
      end

      // Reset mid-scan while sel = 7.
      drive(1, 0, 0, 4'd5, 4'd10, 16'd2);
      cyc();
      drive(0, 0, 0, 4'd0, 4'd0, 16'd0);
      for (int i = 0; i < 4; i++) cyc();
      chk_out("pre_reset", 0, 7, 1, 1, 0);
      rst_n = 1'b0;
      #1;
      chk_out("async_reset", 0, 0, 0, 0, 0);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk_out("after_reset", i, 0, 0, 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
